// File: rtl/aes_pkg.sv
// Shared AES round-datapath types: state/row widths, SubBytes+ShiftRows FSM encoding,
// and a byte-rotate helper.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_ROW_W   = 32;
    localparam int unsigned AES_BYTE_W  = 8;
    localparam int unsigned AES_ROWS    = 4;
    localparam int unsigned AES_ROW_IDX_W = 2;

    typedef logic [AES_STATE_W-1:0]   aes_state_t;
    typedef logic [AES_ROW_W-1:0]     aes_row_t;
    typedef logic [AES_ROW_IDX_W-1:0] aes_row_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ssr_state_e;

    // Rotate a 4-byte row left by n byte positions (ShiftRows for row n).
    function automatic aes_row_t rotl_bytes(input aes_row_t w, input aes_row_idx_t n);
        aes_row_t r;
        unique case (n)
            2'd0:    r = w;
            2'd1:    r = {w[23:0], w[31:24]};
            2'd2:    r = {w[15:0], w[31:16]};
            default: r = {w[7:0],  w[31:8]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sub_shift_rows_if.sv
// Level-enable / ready handshake between the SubBytes+ShiftRows stage and its neighbours.
interface sub_shift_rows_if;
    import aes_pkg::*;

    logic       En_SSR;
    aes_state_t In_SSR;
    logic       Ry_SSR;
    aes_state_t Out_SSR;

    modport master (output En_SSR, output In_SSR, input Ry_SSR, input Out_SSR);
    modport slave  (input En_SSR, input In_SSR, output Ry_SSR, output Out_SSR);

endinterface

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box as a 256-entry case ROM.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (a)
            8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b; 8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
            8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b; 8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
            8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d; 8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
            8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf; 8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
            8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26; 8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
            8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1; 8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
            8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3; 8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
            8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2; 8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
            8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a; 8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
            8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3; 8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
            8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed; 8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
            8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39; 8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
            8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb; 8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
            8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f; 8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
            8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f; 8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
            8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21; 8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
            8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec; 8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
            8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d; 8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
            8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc; 8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
            8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14; 8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
            8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a; 8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
            8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62; 8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
            8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d; 8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
            8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea; 8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
            8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e; 8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
            8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f; 8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
            8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66; 8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
            8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9; 8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
            8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11; 8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
            8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9; 8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
            8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d; 8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
            8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f; 8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
        endcase
    end

endmodule

// File: rtl/sub_shift_rows.sv
// Iterative SubBytes+ShiftRows: one row per cycle through four S-boxes, each row written
// into the output register already rotated by its row index.
module sub_shift_rows
    import aes_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    sub_shift_rows_if.slave ssr
);

    ssr_state_e   state_q, state_d;
    aes_row_idx_t row_q,   row_d;
    aes_state_t   data_q,  data_d;
    aes_state_t   out_q,   out_d;
    logic         ry_q,    ry_d;

    aes_row_t cur_row;
    aes_row_t sub_row;
    aes_row_t rot_row;

    // Row r of the captured state occupies the r-th 32-bit slice from the MSB end.
    always_comb begin
        unique case (row_q)
            2'd0:    cur_row = data_q[127:96];
            2'd1:    cur_row = data_q[95:64];
            2'd2:    cur_row = data_q[63:32];
            default: cur_row = data_q[31:0];
        endcase
    end

    for (genvar i = 0; i < int'(AES_ROWS); i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (cur_row[AES_ROW_W-1-AES_BYTE_W*i -: AES_BYTE_W]),
            .y (sub_row[AES_ROW_W-1-AES_BYTE_W*i -: AES_BYTE_W])
        );
    end

    assign rot_row = rotl_bytes(sub_row, row_q);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        data_d  = data_q;
        out_d   = out_q;
        ry_d    = ry_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ssr.En_SSR) begin
                    data_d  = ssr.In_SSR;
                    row_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!ssr.En_SSR) begin
                    // Abort: rows already written stay in the output register.
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    unique case (row_q)
                        2'd0:    out_d[127:96] = rot_row;
                        2'd1:    out_d[95:64]  = rot_row;
                        2'd2:    out_d[63:32]  = rot_row;
                        default: out_d[31:0]   = rot_row;
                    endcase
                    row_d = row_q + 2'd1;
                    if (row_q == 2'd3) begin
                        state_d = ST_DONE;
                        ry_d    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!ssr.En_SSR) begin
                    state_d = ST_IDLE;
                    ry_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = '0;
                ry_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            data_q  <= '0;
            out_q   <= '0;
            ry_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            data_q  <= data_d;
            out_q   <= out_d;
            ry_q    <= ry_d;
        end
    end

    assign ssr.Ry_SSR  = ry_q;
    assign ssr.Out_SSR = out_q;

endmodule

// File: tb/tb_sub_shift_rows.sv
// Randomized scoreboard bench for sub_shift_rows against a GF(2^8)-arithmetic reference.
module tb_sub_shift_rows;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sub_shift_rows_if ssr_if ();

    sub_shift_rows dut (
        .Clk (clk),
        .Rst (rst),
        .ssr (ssr_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_q [$];
    logic [127:0] cur_exp   = '0;
    logic [127:0] model_out = '0;
    logic         prev_ry   = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x};
        return t[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = '0;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // out(r,c) = S(in(r,(c+r) mod 4)), byte k=4r+c at [127-8k -: 8].
    function automatic logic [127:0] ref_ssr(input logic [127:0] in);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int k, src;
                k   = 4 * r + c;
                src = 4 * r + ((c + r) % 4);
                o[127-8*k -: 8] = sbox_tab[in[127-8*src -: 8]];
            end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: a rising ready pops the next expected result; while ready stays high the output must hold.
    always @(negedge clk) begin
        if (ssr_if.Ry_SSR && !prev_ry) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_ready: got ready with empty queue, out %h at %0t", ssr_if.Out_SSR, $time);
            end else begin
                cur_exp = exp_q.pop_front();
                chk("sb_result", ssr_if.Out_SSR, cur_exp);
            end
        end else if (ssr_if.Ry_SSR) begin
            chk("sb_hold", ssr_if.Out_SSR, cur_exp);
        end
        prev_ry = ssr_if.Ry_SSR;
    end

    task automatic run_op(input logic [127:0] data, input logic [127:0] expv, input int hold);
        @(negedge clk);
        ssr_if.En_SSR = 1'b1;
        ssr_if.In_SSR = data;
        exp_q.push_back(expv);
        model_out = expv;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            if (e < 5) chk("ry_low_busy", 128'(ssr_if.Ry_SSR), 128'(0));
            else       chk("ry_latency", 128'(ssr_if.Ry_SSR), 128'(1));
            ssr_if.In_SSR = rand128();
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            ssr_if.In_SSR = rand128();
        end
        @(negedge clk);
        ssr_if.En_SSR = 1'b0;
        @(posedge clk); #1;
        chk("ry_fall", 128'(ssr_if.Ry_SSR), 128'(0));
        chk("out_retained", ssr_if.Out_SSR, model_out);
    endtask

    task automatic run_abort(input logic [127:0] data, input int k);
        logic [127:0] r;
        r = ref_ssr(data);
        @(negedge clk);
        ssr_if.En_SSR = 1'b1;
        ssr_if.In_SSR = data;
        for (int e = 0; e <= k; e++) begin
            @(posedge clk); #1;
            chk("abort_ry_low", 128'(ssr_if.Ry_SSR), 128'(0));
        end
        @(negedge clk);
        ssr_if.En_SSR = 1'b0;
        @(posedge clk); #1;
        chk("abort_ry_after", 128'(ssr_if.Ry_SSR), 128'(0));
        for (int row = 0; row < k; row++)
            model_out[127-32*row -: 32] = r[127-32*row -: 32];
        chk("abort_out", ssr_if.Out_SSR, model_out);
    endtask

    initial begin
        logic [127:0] spec_abort;
        ssr_if.En_SSR = 1'b0;
        ssr_if.In_SSR = '0;
        build_sbox();

        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ry", 128'(ssr_if.Ry_SSR), 128'(0));
            chk("rst_out", ssr_if.Out_SSR, 128'(0));
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ry", 128'(ssr_if.Ry_SSR), 128'(0));
            chk("idle_out", ssr_if.Out_SSR, 128'(0));
        end

        run_op(128'h19a09ae93df4c6f8e3e28d48be2b2a08, 128'hd4e0b81ebfb441275d52119830aef1e5, 0);
        run_op(128'ha4686b029c9f5b6a7f35ea50f22b4349, 128'h49457f77db3902de8753d2963b89f11a, 10);

        // Reset while mid-row-loop must clear everything immediately.
        @(negedge clk);
        ssr_if.En_SSR = 1'b1;
        ssr_if.In_SSR = rand128();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midbusy_rst_ry", 128'(ssr_if.Ry_SSR), 128'(0));
        chk("midbusy_rst_out", ssr_if.Out_SSR, 128'(0));
        ssr_if.En_SSR = 1'b0;
        model_out = '0;
        @(negedge clk);
        rst = 1'b1;

        run_abort(128'h0, 1);
        spec_abort = 128'h63636363_00000000_00000000_00000000;
        chk("abort_spec_value", ssr_if.Out_SSR, spec_abort);

        run_op(128'h00ff5300_00000000_00000000_00000000, 128'h6316ed63_63636363_63636363_63636363, 2);

        for (int it = 0; it < 24; it++) begin
            logic [127:0] d;
            d = rand128();
            if ($urandom_range(0, 3) == 0) run_abort(d, int'($urandom_range(0, 3)));
            else                           run_op(d, ref_ssr(d), int'($urandom_range(0, 5)));
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_shift_rows.md
# sub_shift_rows

Iterative SubBytes + ShiftRows stage of the AES round datapath, placed directly upstream of the MixColumns stage. It feeds that stage through the same level-enable / ready handshake. It captures a 128-bit state and substitutes one row (4 bytes) per cycle through four S-box instances. Each substituted row is written into the output register already rotated by its row index. The resulting `Out_SSR` connects without further logic to the MixColumns `In` port.

## Interface
Parameters:
- none. Width is fixed at 128 bits, 4x4 bytes.

Ports:
- `Clk`  in  1  system clock, rising-edge.
- `Rst`  in  1  reset, asynchronous, active-low. `Rst=0` clears all state immediately.
- `En_SSR`  in  1  level enable / start request. Must stay high until `Ry_SSR` is seen.
- `In_SSR`  in  128  input state, sampled on the start edge only.
- `Ry_SSR`  out  1  ready. High while `Out_SSR` holds a complete result.
- `Out_SSR`  out  128  substituted and shifted state, registered.

## Operation
- State packing is row-major, as used throughout the round datapath.
  - Byte k = 4r+c sits at `[127-8k -: 8]`, which is element s(r,c).
  - Row r is bits `[127-32r -: 32]`.
- Transform: out(r,c) = S(in(r,(c+r) mod 4)). S is the FIPS-197 forward S-box.
  - Row r result = rotate-left-by-r-bytes of (S applied to each byte of input row r).
- FSM states: IDLE, BUSY, DONE. A 2-bit row counter `row` runs only in BUSY.
  - IDLE, `En_SSR=1`: capture `In_SSR` into an internal state register, `row<=0`, go to BUSY.
  - IDLE, `En_SSR=0`: stay in IDLE.
  - BUSY, `En_SSR=1`: write the rotated, substituted row `row` into `Out_SSR`, `row<=row+1`.
    - If `row==3`: go to DONE and set `Ry_SSR<=1` on the same edge.
  - BUSY, `En_SSR=0`: abort to IDLE. `Ry_SSR` stays 0. Rows already written remain in `Out_SSR`; the other rows keep their previous content.
  - DONE, `En_SSR=1`: hold. `Out_SSR` and `Ry_SSR=1` are stable. No restart.
  - DONE, `En_SSR=0`: go to IDLE and clear `Ry_SSR<=0`. `Out_SSR` is retained.
- A new operation requires `En_SSR` low for at least one cycle after DONE.
- `In_SSR` changes after the capture edge are ignored.
- `Rst=0` in any state, including mid-BUSY, does the following immediately (asynchronous):
  - FSM goes to IDLE, `row=0`.
  - `Ry_SSR=0`, `Out_SSR=128'h0`, internal state register = 0.
- Reset values: `Ry_SSR=0`, `Out_SSR=0`.

## Timing
- Edge E0: `En_SSR` is sampled high in IDLE and the input is captured.
- Edges E1..E4: rows 0..3 are written.
- `Ry_SSR` rises after E4. Latency is 5 clock edges from the start edge.
- `Ry_SSR` falls one edge after `En_SSR` is sampled low in DONE.
- S-box lookup is combinational from the captured state register. There is no S-box pipeline register.

## Structure
- Package `aes_pkg` holds:
  - FSM state encoding (`ST_IDLE`, `ST_BUSY`, `ST_DONE`).
  - Constants `AES_STATE_W=128` and `AES_ROW_W=32`.
- Sub-module `aes_sbox`: combinational 8-bit in / 8-bit out forward S-box, a 256-entry case ROM.
  - Instantiated 4 times, once per byte of the current row.
  - Reusable by the key-expansion block.
- Top level contains the FSM, row counter, row multiplexer, byte rotator and output register.

## Test plan
- Reset and idle:
  - Drive `Rst=0` with `En_SSR=0`, then release. Expect `Ry_SSR=0` and `Out_SSR=0` throughout.
  - Drive `Rst=0` mid-BUSY. Expect immediate `Ry_SSR=0` and `Out_SSR=0`.
- FIPS-197 round 1:
  - `In_SSR=128'h19a09ae93df4c6f8e3e28d48be2b2a08`, `En_SSR=1`.
  - After 5 edges expect `Ry_SSR=1` and `Out_SSR=128'hd4e0b81ebfb441275d52119830aef1e5`.
  - `Ry_SSR` must be 0 after edges 1..4.
- FIPS-197 round 2:
  - Pulse `En_SSR` low for one cycle, then `In_SSR=128'ha4686b029c9f5b6a7f35ea50f22b4349`.
  - Expect `Out_SSR=128'h49457f77db3902de8753d2963b89f11a` and `Ry_SSR=1` after 5 edges.
- Hold in DONE:
  - Keep `En_SSR=1` for 10 cycles after ready while changing `In_SSR`. Expect `Out_SSR` and `Ry_SSR=1` unchanged.
  - Drop `En_SSR`. Expect `Ry_SSR=0` next edge, `Out_SSR` retained.
- Abort:
  - Start from `Out_SSR=0` with `In_SSR=0` and `En_SSR=1` for 2 edges only (capture, then row 0 written), then drop.
  - Expect `Ry_SSR` never high and `Out_SSR=128'h63636363_00000000_00000000_00000000`.
- S-box corner values:
  - `In_SSR=128'h00ff5300_00000000_00000000_00000000`.
  - Expect `Out_SSR=128'h6316ed63_63636363_63636363_63636363`.
